// File: rtl/jk_flipflop.sv
// Bank of WIDTH independent edge-triggered JK flip-flops.
// All bits share one clock enable, and q_bar is the bitwise complement of q.

module jk_bit #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic en_i,
  input  logic j_i,
  input  logic k_i,
  output logic q_o
);
  logic q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (en_i) begin
      case ({j_i, k_i})
        2'b01:   q_d = 1'b0;
        2'b10:   q_d = 1'b1;
        2'b11:   q_d = ~q_q;
        default: q_d = q_q;
      endcase
    end
  end

  // Reset is sampled on the edge and takes priority over enable and J/K.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) q_q <= RESET_VAL;
    else          q_q <= q_d;
  end

  assign q_o = q_q;
endmodule

module jk_flipflop #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  input  logic             en,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar
);
  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    jk_bit #(.RESET_VAL(RESET_VAL[g])) u_bit (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .en_i    (en),
      .j_i     (j[g]),
      .k_i     (k[g]),
      .q_o     (q[g])
    );
  end

  assign q_bar = ~q;
endmodule

// File: tb/tb_jk_flipflop.sv
// Scoreboard bench: three instances (1-bit reset-0, 1-bit reset-1, 4-bit)
// share rst_n/en; each edge's hand-computed result is queued and checked.
`timescale 1ns/1ps
module tb_jk_flipflop;
  logic       clk = 1'b0;
  logic       rst_n, en;
  logic [0:0] j1, k1;
  logic [3:0] j4, k4;
  logic [0:0] qa, qa_bar, qb, qb_bar;
  logic [3:0] qc, qc_bar;

  typedef struct {
    int         idx;
    logic       ea;
    logic       eb;
    logic [3:0] ec;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   row   = 0;

  always #5 clk = ~clk;

  jk_flipflop #(.WIDTH(1), .RESET_VAL(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_n), .j(j1), .k(k1), .en(en), .q(qa), .q_bar(qa_bar));
  jk_flipflop #(.WIDTH(1), .RESET_VAL(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .j(j1), .k(k1), .en(en), .q(qb), .q_bar(qb_bar));
  jk_flipflop #(.WIDTH(4)) dut_c (
    .clk(clk), .rst_n(rst_n), .j(j4), .k(k4), .en(en), .q(qc), .q_bar(qc_bar));

  // Monitor: one expectation per rising edge once stimulus starts.
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_cmp += 3;
      if (qa !== e.ea || qa_bar !== ~e.ea) begin
        n_bad++;
        $display("FAIL row%0d w1_rv0: q=%b q_bar=%b expected q=%b", e.idx, qa, qa_bar, e.ea);
      end
      if (qb !== e.eb || qb_bar !== ~e.eb) begin
        n_bad++;
        $display("FAIL row%0d w1_rv1: q=%b q_bar=%b expected q=%b", e.idx, qb, qb_bar, e.eb);
      end
      if (qc !== e.ec || qc_bar !== ~e.ec) begin
        n_bad++;
        $display("FAIL row%0d w4: q=%b q_bar=%b expected q=%b", e.idx, qc, qc_bar, e.ec);
      end
    end
  end

  task automatic step(input logic r, input logic e, input logic j, input logic k,
                      input logic [3:0] jw, input logic [3:0] kw,
                      input logic ea, input logic eb, input logic [3:0] ec);
    exp_t x;
    @(negedge clk);
    rst_n = r; en = e; j1 = j; k1 = k; j4 = jw; k4 = kw;
    x.idx = row; x.ea = ea; x.eb = eb; x.ec = ec;
    sb.push_back(x);
    row++;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; j1 = 1'b1; k1 = 1'b1; j4 = 4'hF; k4 = 4'hF;
    //   rst en j k  j4    k4     qa qb qc
    step(0, 1, 1, 1, 4'hF, 4'hF, 0, 1, 4'h0);   // reset with J=K=1
    step(0, 1, 1, 1, 4'hF, 4'hF, 0, 1, 4'h0);
    step(1, 1, 0, 0, 4'h0, 4'h0, 0, 1, 4'h0);   // function table
    step(1, 1, 1, 0, 4'h0, 4'h0, 1, 1, 4'h0);
    step(1, 1, 0, 0, 4'h0, 4'h0, 1, 1, 4'h0);
    step(1, 1, 0, 1, 4'h0, 4'h0, 0, 0, 4'h0);
    step(1, 1, 1, 1, 4'h0, 4'h0, 1, 1, 4'h0);
    step(1, 1, 1, 1, 4'h0, 4'h0, 0, 0, 4'h0);
    step(1, 1, 1, 0, 4'h0, 4'h0, 1, 1, 4'h0);   // set before gating
    step(1, 0, 0, 1, 4'hF, 4'hF, 1, 1, 4'h0);   // en=0 ignores J/K
    step(1, 0, 1, 0, 4'hF, 4'h0, 1, 1, 4'h0);
    step(1, 0, 1, 1, 4'hF, 4'hF, 1, 1, 4'h0);
    step(1, 1, 0, 1, 4'h0, 4'h0, 0, 0, 4'h0);
    step(1, 1, 1, 1, 4'hA, 4'h6, 1, 1, 4'hA);   // toggle run + mixed bits
    step(1, 1, 1, 1, 4'hA, 4'h6, 0, 0, 4'h8);
    step(1, 1, 1, 1, 4'hA, 4'h6, 1, 1, 4'hA);
    step(1, 1, 1, 1, 4'hA, 4'h6, 0, 0, 4'h8);
    step(1, 1, 1, 1, 4'hA, 4'h6, 1, 1, 4'hA);
    step(1, 1, 1, 1, 4'hF, 4'hF, 0, 0, 4'h5);   // toggle all bits
    step(0, 1, 1, 1, 4'hF, 4'hF, 0, 1, 4'h0);   // reset mid-toggle
    step(1, 1, 1, 1, 4'hF, 4'hF, 1, 0, 4'hF);   // resume from reset value
    step(1, 1, 1, 1, 4'hF, 4'hF, 0, 1, 4'h0);
    step(1, 1, 0, 0, 4'h3, 4'hC, 0, 1, 4'h3);
    step(0, 0, 0, 0, 4'h0, 4'h0, 0, 1, 4'h0);   // reset ignores en=0
    for (int w = 0; w < 20 && sb.size() > 0; w++) @(posedge clk);
    #2;
    if (sb.size() > 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
